// File: rtl/dds_multimode.sv
// Multi-waveform DDS: phase accumulator with deferred (wrap-aligned) setting updates,
// quarter-wave sine ROM plus square/triangle/sawtooth, two-stage registered output.
module dds_multimode #(
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 6,
  parameter int OUT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               load,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [PHASE_W-1:0] phase_off,
  input  logic [1:0]         mode,
  output logic               pending,
  output logic               wrap,
  output logic [OUT_W-1:0]   out,
  output logic               out_valid
);

  localparam logic [1:0] MODE_SINE   = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;

  localparam int MAG_W    = OUT_W - 1;
  localparam int LUT_N    = 2 ** LUT_AW;
  localparam int LUT_BITS = LUT_N * MAG_W;

  // Lowest phase bit any waveform looks at; bits below it are never registered.
  localparam int P_LO = ((PHASE_W - 2 - LUT_AW) < (PHASE_W - 1 - OUT_W)) ?
                        (PHASE_W - 2 - LUT_AW) : (PHASE_W - 1 - OUT_W);
  localparam int P_W  = PHASE_W - P_LO;

  localparam logic [OUT_W-1:0] MID  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [MAG_W-1:0] FULL = '1;
  localparam longint PI_Q30 = 64'd3373259426;

  // Quarter-wave table round((M-1)*sin(k*pi/2^(LUT_AW+1))), built at elaboration
  // with a Q30 Taylor series so no memory file is needed.
  function automatic logic [LUT_BITS-1:0] build_lut();
    longint x, x2, term, sum, amp, val;
    logic [LUT_BITS-1:0] tbl;
    tbl = '0;
    amp = (longint'(1) <<< (OUT_W - 1)) - 1;
    for (int k = 0; k < LUT_N; k++) begin
      x    = (longint'(k) * PI_Q30) >>> (LUT_AW + 1);
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int n = 1; n <= 10; n++) begin
        term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
        sum  = sum + term;
      end
      val = (amp * sum + (longint'(1) <<< 29)) >>> 30;
      tbl[k*MAG_W +: MAG_W] = MAG_W'(val);
    end
    return tbl;
  endfunction

  localparam logic [LUT_BITS-1:0] LUT = build_lut();

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] f_act_q, f_act_d, o_act_q, o_act_d;
  logic [1:0]         m_act_q, m_act_d;
  logic [PHASE_W-1:0] f_pend_q, f_pend_d, o_pend_q, o_pend_d;
  logic [1:0]         m_pend_q, m_pend_d;
  logic               pend_q, pend_d;
  logic               wrap_q;
  logic [P_W-1:0]     p_q, p_d;
  logic [1:0]         m_q;
  logic               v1_q;
  logic [OUT_W-1:0]   out_q, wave_d;
  logic               out_valid_q;

  logic [PHASE_W:0]   sum_w;
  logic               carry, apply;

  always_comb begin
    sum_w = {1'b0, acc_q} + {1'b0, f_act_q};
    carry = en & sum_w[PHASE_W];
    // Settings switch only at a wrap, or immediately while the accumulator is idle.
    apply = (pend_q | load) & (carry | ~en);

    acc_d    = en ? sum_w[PHASE_W-1:0] : acc_q;
    f_pend_d = load ? freq_word : f_pend_q;
    o_pend_d = load ? phase_off : o_pend_q;
    m_pend_d = load ? mode      : m_pend_q;

    f_act_d = f_act_q;
    o_act_d = o_act_q;
    m_act_d = m_act_q;
    if (apply) begin
      f_act_d = load ? freq_word : f_pend_q;
      o_act_d = load ? phase_off : o_pend_q;
      m_act_d = load ? mode      : m_pend_q;
    end

    if (apply)     pend_d = 1'b0;
    else if (load) pend_d = 1'b1;
    else           pend_d = pend_q;

    p_d = P_W'((acc_q + o_act_q) >> P_LO);
  end

  logic [1:0]        sin_q;
  logic [LUT_AW-1:0] sin_idx, sin_ridx;
  logic [MAG_W-1:0]  mag;
  logic [OUT_W-1:0]  tri_t;

  always_comb begin
    sin_q    = p_q[P_W-1 -: 2];
    sin_idx  = p_q[P_W-3 -: LUT_AW];
    sin_ridx = -sin_idx;
    tri_t    = p_q[P_W-2 -: OUT_W];

    // Odd quadrants read the table mirrored; index 0 there is the peak itself.
    if (!sin_q[0])          mag = LUT[int'(sin_idx) * MAG_W +: MAG_W];
    else if (sin_idx == '0) mag = FULL;
    else                    mag = LUT[int'(sin_ridx) * MAG_W +: MAG_W];

    case (m_q)
      MODE_SINE:   wave_d = sin_q[1] ? (MID - {1'b0, mag}) : (MID + {1'b0, mag});
      MODE_SQUARE: wave_d = p_q[P_W-1] ? '0 : '1;
      MODE_TRI:    wave_d = p_q[P_W-1] ? ~tri_t : tri_t;
      default:     wave_d = p_q[P_W-1 -: OUT_W];
    endcase
  end

  // out_valid marks a sample from an enabled step; it trails en by two cycles and
  // out only updates alongside it, so an idle DDS holds its last sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      f_act_q     <= '0;
      o_act_q     <= '0;
      m_act_q     <= MODE_SINE;
      f_pend_q    <= '0;
      o_pend_q    <= '0;
      m_pend_q    <= '0;
      pend_q      <= 1'b0;
      wrap_q      <= 1'b0;
      p_q         <= '0;
      m_q         <= MODE_SINE;
      v1_q        <= 1'b0;
      out_q       <= MID;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      f_act_q     <= f_act_d;
      o_act_q     <= o_act_d;
      m_act_q     <= m_act_d;
      f_pend_q    <= f_pend_d;
      o_pend_q    <= o_pend_d;
      m_pend_q    <= m_pend_d;
      pend_q      <= pend_d;
      wrap_q      <= carry;
      p_q         <= p_d;
      m_q         <= m_act_q;
      v1_q        <= en;
      if (v1_q) out_q <= wave_d;
      out_valid_q <= v1_q;
    end
  end

  assign pending   = pend_q;
  assign wrap      = wrap_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dds_multimode.sv
// Directed bench for dds_multimode: reset, each waveform, offset, deferred loads,
// load on the carry cycle and reset with settings pending.
module tb_dds_multimode;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [15:0] freq_word, phase_off;
  logic [1:0]  mode;
  logic        pending, wrap, out_valid;
  logic [7:0]  out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dds_multimode dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .freq_word (freq_word),
    .phase_off (phase_off),
    .mode      (mode),
    .pending   (pending),
    .wrap      (wrap),
    .out       (out),
    .out_valid (out_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reset, load settings while idle (applied at once), then enable; returns after
  // the first enabled edge so the next tick shows the sample at p = offset.
  task automatic start(input logic [1:0] m, input logic [15:0] f, input logic [15:0] o);
    rst = 1'b1; en = 1'b0; load = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    mode = m; freq_word = f; phase_off = o; load = 1'b1;
    tick();
    load = 1'b0;
    check("apply_idle", pending, 0);
    en = 1'b1;
    tick();
    check("valid_lag", out_valid, 0);
  endtask

  initial begin
    int e;
    rst = 1'b1; en = 1'b1; load = 1'b1;
    freq_word = 16'h1234; phase_off = 16'h1111; mode = 2'd3;
    tick(); tick(); tick();
    check("rst_out", out, 128);
    check("rst_valid", out_valid, 0);
    check("rst_pending", pending, 0);
    check("rst_wrap", wrap, 0);
    rst = 1'b0; load = 1'b0;
    tick();
    check("rel_pending", pending, 0);
    check("rel_valid", out_valid, 0);
    tick();
    check("rel_valid2", out_valid, 1);
    check("rel_acc0", out, 128);

    // Sine, step 0x0400
    start(2'd0, 16'h0400, 16'h0000);
    for (int j = 0; j < 128; j++) begin
      tick();
      check("sine_wrap", wrap, (j == 62 || j == 126) ? 1 : 0);
      case (j)
        0:  e = 128;
        1:  e = 140;
        8:  e = 218;
        16: e = 255;
        17: e = 254;
        32: e = 128;
        40: e = 38;
        48: e = 1;
        default: e = -1;
      endcase
      if (j == 0) check("sine_valid", out_valid, 1);
      if (e >= 0) check("sine_out", out, e);
    end

    start(2'd1, 16'h1000, 16'h0000);
    for (int j = 0; j < 32; j++) begin
      tick();
      check("square", out, ((j % 16) < 8) ? 255 : 0);
    end

    start(2'd3, 16'h0100, 16'h0000);
    for (int j = 0; j <= 256; j++) begin
      tick();
      check("saw", out, j % 256);
    end

    start(2'd2, 16'h0100, 16'h0000);
    for (int j = 0; j <= 256; j++) begin
      tick();
      check("tri", out, (j < 128) ? 2 * j : ((j < 256) ? 255 - 2 * (j - 128) : 0));
    end

    // Offset 0x4000 puts the first sample at the sine peak, then en drops.
    start(2'd0, 16'h0400, 16'h4000);
    tick();
    check("off_first", out, 255);
    check("off_valid", out_valid, 1);
    en = 1'b0;
    tick();
    check("off_second", out, 254);
    check("off_valid2", out_valid, 1);
    tick();
    check("hold_valid", out_valid, 0);
    check("hold_out", out, 254);
    tick();
    check("hold_out2", out, 254);
    check("hold_wrap", wrap, 0);

    // Deferred loads on a sawtooth: out after tick k shows acc value from two edges earlier.
    start(2'd3, 16'h0400, 16'h0000);
    for (int k = 1; k <= 196; k++) begin
      tick();
      case (k)
        12:  check("pend_set", pending, 1);
        14:  check("pend_set2", pending, 1);
        20:  check("old_step", out, 76);
        62:  check("pend_hold", pending, 1);
        63: begin
          check("apply_clr", pending, 0);
          check("apply_wrap", wrap, 1);
          check("pre_wrap", out, 248);
        end
        64: begin
          check("pre_wrap2", out, 252);
          check("post_wrap", wrap, 0);
        end
        65:  check("wrap_zero", out, 0);
        66:  check("new_step", out, 2);
        67:  check("last_wins", out, 4);
        190: check("cl_idle", pending, 0);
        191: begin
          check("cl_pending", pending, 0);
          check("cl_wrap", wrap, 1);
        end
        192: check("cl_pre", out, 254);
        193: check("cl_zero", out, 0);
        194: check("cl_step", out, 16);
        195: check("cl_step2", out, 32);
        196: check("mid_pend", pending, 1);
        default: ;
      endcase
      load      = (k == 11 || k == 13 || k == 190 || k == 195);
      freq_word = (k == 11) ? 16'h0800 : (k == 13) ? 16'h0200 : (k == 190) ? 16'h1000 : 16'h0100;
      mode      = (k == 195) ? 2'd0 : 2'd3;
    end

    // Reset with settings pending: the pending set must be discarded.
    load = 1'b0;
    rst  = 1'b1;
    tick();
    check("mrst_out", out, 128);
    check("mrst_valid", out_valid, 0);
    check("mrst_pending", pending, 0);
    check("mrst_wrap", wrap, 0);
    rst = 1'b0;
    tick();
    check("mrst_valid2", out_valid, 0);
    tick();
    check("f0_valid", out_valid, 1);
    check("f0_out", out, 128);
    en = 1'b0;
    tick();
    en = 1'b1;
    tick(); tick(); tick(); tick();
    check("no_stale", out, 128);
    check("no_stale_pend", pending, 0);
    check("f0_wrap", wrap, 0);
    check("f0_valid2", out_valid, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
